// File: rtl/pipe_stage_chain.sv
// Chain of DEPTH valid/allowin pipeline stage registers with partial flush,
// registered occupancy and saturating bubble/kill counters.
module pipe_stage_chain #(
  parameter int DEPTH = 4,
  parameter int BUS_W = 64,
  parameter int CNT_W = 32,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [BUS_W-1:0]       in_bus,
  output logic                   in_allowin,
  input  logic [DEPTH-1:0]       stage_ready_go,
  output logic [DEPTH-1:0]       stage_valid,
  output logic [DEPTH*BUS_W-1:0] stage_bus,
  output logic                   out_valid,
  output logic [BUS_W-1:0]       out_bus,
  input  logic                   out_allowin,
  input  logic                   flush,
  input  logic [IDX_W-1:0]       flush_stage,
  output logic [IDX_W:0]         occupancy,
  output logic [CNT_W-1:0]       bubble_cnt,
  output logic [CNT_W-1:0]       kill_cnt
);

  // Handshake: an entry moves into stage i on a clock edge exactly when
  // src_valid(i) & allowin(i); out transfer happens when out_valid & out_allowin.

  logic [DEPTH-1:0] r_valid;
  logic [BUS_W-1:0] r_bus [DEPTH];
  logic [IDX_W:0]   r_occ;
  logic [CNT_W-1:0] r_bubble;
  logic [CNT_W-1:0] r_kill;

  logic [DEPTH-1:0] w_allowin;
  logic [DEPTH-1:0] w_to_next;
  logic [DEPTH-1:0] w_src_valid;
  logic [DEPTH-1:0] w_kill;
  logic [DEPTH-1:0] w_load;
  logic [DEPTH-1:0] w_nxt_valid;
  logic [BUS_W-1:0] w_src_bus [DEPTH];
  logic [IDX_W-1:0] w_fs;
  logic [IDX_W:0]   w_nxt_occ;
  logic [IDX_W:0]   w_kill_n;
  logic [CNT_W:0]   w_kill_sum;

  assign w_fs = (int'(flush_stage) > DEPTH - 1) ? IDX_W'(DEPTH - 1) : flush_stage;

  always_comb begin
    logic l_nxt_allowin;
    w_allowin   = '0;
    w_to_next   = '0;
    w_src_valid = '0;
    w_kill      = '0;
    w_load      = '0;
    w_nxt_valid = r_valid;
    w_nxt_occ   = '0;
    w_kill_n    = '0;
    l_nxt_allowin = out_allowin;
    for (int i = 0; i < DEPTH; i++) begin
      w_kill[i]    = flush && (i <= int'(w_fs));
      w_to_next[i] = r_valid[i] & stage_ready_go[i];
    end
    // Ripple from the exit back to the entry; no registers in this path.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_allowin[i]  = !r_valid[i] | (stage_ready_go[i] & l_nxt_allowin);
      l_nxt_allowin = w_allowin[i];
    end
    w_src_valid[0] = in_valid;
    w_src_bus[0]   = in_bus;
    for (int i = 1; i < DEPTH; i++) begin
      // A killed stage hands nothing forward, so its older neighbour loads a bubble.
      w_src_valid[i] = w_to_next[i-1] & !w_kill[i-1];
      w_src_bus[i]   = r_bus[i-1];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (w_kill[i]) begin
        w_nxt_valid[i] = 1'b0;
      end else if (w_allowin[i]) begin
        w_nxt_valid[i] = w_src_valid[i];
        w_load[i]      = w_src_valid[i];
      end
      w_nxt_occ = w_nxt_occ + (IDX_W+1)'(w_nxt_valid[i]);
      w_kill_n  = w_kill_n + (IDX_W+1)'(r_valid[i] & w_kill[i]);
    end
    w_kill_sum = {1'b0, r_kill} + (CNT_W+1)'(w_kill_n);
  end

  assign in_allowin  = flush | w_allowin[0];
  assign out_valid   = w_to_next[DEPTH-1] & !w_kill[DEPTH-1];
  assign out_bus     = r_bus[DEPTH-1];
  assign stage_valid = r_valid;
  assign occupancy   = r_occ;
  assign bubble_cnt  = r_bubble;
  assign kill_cnt    = r_kill;

  for (genvar g = 0; g < DEPTH; g++) begin : g_bus
    assign stage_bus[g*BUS_W +: BUS_W] = r_bus[g];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid  <= '0;
      r_occ    <= '0;
      r_bubble <= '0;
      r_kill   <= '0;
      for (int i = 0; i < DEPTH; i++) r_bus[i] <= '0;
    end else begin
      r_valid <= w_nxt_valid;
      r_occ   <= w_nxt_occ;
      for (int i = 0; i < DEPTH; i++) begin
        if (w_load[i]) r_bus[i] <= w_src_bus[i];
      end
      if (!out_valid && (r_bubble != '1)) r_bubble <= r_bubble + 1'b1;
      r_kill <= w_kill_sum[CNT_W] ? '1 : w_kill_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: directed scenarios plus randomized traffic, with an
// in-order scoreboard of accepted payloads and a saturating kill-count model.
module tb_pipe_stage_chain;

  localparam int DEPTH = 4;
  localparam int BUS_W = 64;
  localparam int CNT_W = 4;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                   clk;
  logic                   reset;
  logic                   in_valid;
  logic [BUS_W-1:0]       in_bus;
  logic                   in_allowin;
  logic [DEPTH-1:0]       stage_ready_go;
  logic [DEPTH-1:0]       stage_valid;
  logic [DEPTH*BUS_W-1:0] stage_bus;
  logic                   out_valid;
  logic [BUS_W-1:0]       out_bus;
  logic                   out_allowin;
  logic                   flush;
  logic [IDX_W-1:0]       flush_stage;
  logic [IDX_W:0]         occupancy;
  logic [CNT_W-1:0]       bubble_cnt;
  logic [CNT_W-1:0]       kill_cnt;

  pipe_stage_chain #(.DEPTH(DEPTH), .BUS_W(BUS_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bus(in_bus),
    .in_allowin(in_allowin), .stage_ready_go(stage_ready_go),
    .stage_valid(stage_valid), .stage_bus(stage_bus), .out_valid(out_valid),
    .out_bus(out_bus), .out_allowin(out_allowin), .flush(flush),
    .flush_stage(flush_stage), .occupancy(occupancy),
    .bubble_cnt(bubble_cnt), .kill_cnt(kill_cnt)
  );

  int checks = 0;
  int errors = 0;
  logic [BUS_W-1:0] exp_q[$];
  int  exp_kill = 0;
  bit  mon_en = 0;
  bit  flush_all = 0;
  int  kill_n = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    step();
    reset = 1'b0;
  endtask

  function automatic logic [BUS_W-1:0] rand_bus();
    return {$urandom, $urandom};
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
      chk("kill_cnt", 64'(kill_cnt), 64'(exp_kill));
      if (reset) begin
        exp_q.delete();
        exp_kill = 0;
      end else begin
        if (out_valid && out_allowin) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_unexpected: got 0x%0h, expected no output", out_bus);
          end else begin
            chk("out_bus", out_bus, exp_q.pop_front());
          end
        end
        if (flush) begin
          int n;
          n = flush_all ? exp_q.size() : kill_n;
          for (int k = 0; k < n; k++) void'(exp_q.pop_back());
          exp_kill = (exp_kill + n > CNT_MAX) ? CNT_MAX : exp_kill + n;
        end
        if (in_valid && in_allowin && !flush) exp_q.push_back(in_bus);
      end
    end
  end

  initial begin
    logic [BUS_W-1:0] exp_stage [DEPTH];
    logic [BUS_W-1:0] exp_e1;
    reset = 1'b1; in_valid = 1'b0; in_bus = '0; stage_ready_go = '1;
    out_allowin = 1'b1; flush = 1'b0; flush_stage = '0;
    step();
    mon_en = 1'b1;
    step();
    @(negedge clk);
    chk("rst_stage_valid", 64'(stage_valid), 64'h0);
    chk("rst_stage_bus_zero", 64'(stage_bus == '0), 64'h1);
    chk("rst_occupancy", 64'(occupancy), 64'h0);
    chk("rst_bubble", 64'(bubble_cnt), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);

    // latency of a single entry
    step();
    reset = 1'b0;
    in_valid = 1'b1;
    in_bus = 64'h1111_1111_1111_1111;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("lat_out_valid_%0d", k), 64'(out_valid), (k == 4) ? 64'h1 : 64'h0);
    end
    chk("lat_out_bus", out_bus, 64'h1111_1111_1111_1111);
    chk("lat_bubble", 64'(bubble_cnt), 64'h4);

    // back-to-back stream of 8
    step();
    for (int e = 0; e < 8; e++) begin
      in_valid = 1'b1;
      in_bus = rand_bus();
      @(negedge clk);
      if (e >= 4) begin
        chk("stream_out_valid", 64'(out_valid), 64'h1);
        chk("stream_occupancy", 64'(occupancy), 64'h4);
      end
      step();
    end
    in_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("stream_tail_valid", 64'(out_valid), 64'h1);
    end
    @(negedge clk);
    chk("stream_end_valid", 64'(out_valid), 64'h0);

    // downstream backpressure
    step();
    out_allowin = 1'b0;
    for (int j = 0; j < 6; j++) begin
      in_valid = 1'b1;
      in_bus = rand_bus();
      if (j >= 4) begin
        for (int i = 0; i < DEPTH; i++) exp_stage[i] = exp_q[DEPTH-1-i];
      end
      @(negedge clk);
      if (j >= 4) begin
        chk("bp_in_allowin", 64'(in_allowin), 64'h0);
        chk("bp_occupancy", 64'(occupancy), 64'h4);
        for (int i = 0; i < DEPTH; i++)
          chk($sformatf("bp_stage_bus_%0d", i), stage_bus[i*BUS_W +: BUS_W], exp_stage[i]);
      end
      step();
    end
    out_allowin = 1'b1;
    in_valid = 1'b0;
    repeat (8) step();

    // stage 1 stalls for two cycles
    do_reset();
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1;
      in_bus = rand_bus();
      stage_ready_go = (c == 6 || c == 7) ? 4'b1101 : 4'b1111;
      @(negedge clk);
      if (c == 6 || c == 7) begin
        chk("stall_in_allowin", 64'(in_allowin), 64'h0);
        chk("stall_hold_01", 64'(stage_valid[1:0]), 64'h3);
      end
      if (c == 7 || c == 8) chk("stall_bubble_s2", 64'(stage_valid[2]), 64'h0);
      if (c == 8 || c == 9) chk("stall_bubble_s3", 64'(stage_valid[3]), 64'h0);
      step();
    end
    @(negedge clk);
    chk("stall_bubble_cnt", 64'(bubble_cnt), 64'h6);
    step();
    in_valid = 1'b0;
    repeat (6) step();

    // partial flush of a full chain
    do_reset();
    out_allowin = 1'b0;
    for (int j = 0; j < 4; j++) begin
      in_valid = 1'b1;
      in_bus = rand_bus();
      step();
    end
    exp_e1 = exp_q[1];
    in_bus = rand_bus();
    out_allowin = 1'b1;
    flush = 1'b1;
    flush_stage = 2'd1;
    kill_n = 2;
    @(negedge clk);
    chk("flush_in_allowin", 64'(in_allowin), 64'h1);
    chk("flush_out_valid", 64'(out_valid), 64'h1);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_stage_valid", 64'(stage_valid), 64'h8);
    chk("flush_kill_cnt", 64'(kill_cnt), 64'h2);
    chk("flush_s3_bus", stage_bus[3*BUS_W +: BUS_W], exp_e1);
    repeat (4) step();

    // bubble saturation, then reset mid-stream
    do_reset();
    repeat (20) step();
    @(negedge clk);
    chk("sat_bubble", 64'(bubble_cnt), 64'hF);
    step();
    in_valid = 1'b1;
    repeat (3) begin
      in_bus = rand_bus();
      step();
    end
    do_reset();
    @(negedge clk);
    chk("midrst_stage_valid", 64'(stage_valid), 64'h0);
    chk("midrst_occupancy", 64'(occupancy), 64'h0);
    chk("midrst_bubble", 64'(bubble_cnt), 64'h0);
    chk("midrst_kill", 64'(kill_cnt), 64'h0);
    chk("midrst_bus_zero", 64'(stage_bus == '0), 64'h1);
    step();

    // randomized traffic with occasional full flushes
    flush_all = 1'b1;
    flush_stage = 2'(DEPTH - 1);
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_bus = rand_bus();
      for (int i = 0; i < DEPTH; i++) stage_ready_go[i] = ($urandom_range(0, 3) != 0);
      out_allowin = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 49) == 0);
      step();
    end
    flush = 1'b0;
    flush_all = 1'b0;
    in_valid = 1'b0;
    stage_ready_go = '1;
    out_allowin = 1'b1;
    repeat (8) step();
    @(negedge clk);
    chk("drain_occupancy", 64'(occupancy), 64'h0);
    chk("drain_queue_empty", 64'(exp_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
